// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared types and constants for the serial sequence detector
package sd_pkg;

   localparam int         HIST_W  = 8;
   localparam logic [3:0] LEN_MAX = 4'd8;

   typedef enum logic [1:0] {
      SD_IDLE  = 2'b00,
      SD_SHIFT = 2'b01
   } sd_state_t;

   // Pattern lengths above the history width behave as a full-width compare
   function automatic logic [3:0] clamp_len(input logic [3:0] len);
      return (len > LEN_MAX) ? LEN_MAX : len;
   endfunction

endpackage

// File: rtl/sd_shift_match.sv
// rtl/sd_shift_match.sv - bit history, fill tracking and masked pattern compare
module sd_shift_match
   import sd_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   input  logic              i_shift_en,
   input  logic              i_bit,
   input  logic [3:0]        i_len,
   input  logic [HIST_W-1:0] i_pattern,
   output logic              o_hit
);

   logic [HIST_W-1:0] r_history;
   logic [3:0]        r_fill;
   logic [HIST_W-1:0] w_next_history;
   logic [HIST_W-1:0] w_mask;
   logic [3:0]        w_next_fill;

   // Compare the history as it will look after this edge; a clear discards the bit
   always_comb begin
      w_next_history = {r_history[HIST_W-2:0], i_bit};
      w_next_fill    = (r_fill >= LEN_MAX) ? LEN_MAX : r_fill + 4'd1;
      w_mask         = '0;
      for (int i = 0; i < HIST_W; i++) begin
         if (4'(i) < i_len) begin
            w_mask[i] = 1'b1;
         end
      end
      o_hit = i_shift_en && !i_clr && (i_len != 4'd0) && (w_next_fill >= i_len) &&
              (((w_next_history ^ i_pattern) & w_mask) == '0);
   end

   // History and fill advance one bit per shifting edge and survive idle gaps
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_history <= '0;
         r_fill    <= '0;
      end else if (i_clr) begin
         r_history <= '0;
         r_fill    <= '0;
      end else if (i_shift_en) begin
         r_history <= w_next_history;
         r_fill    <= w_next_fill;
      end
   end

endmodule

// File: rtl/sd_stream_ctrl.sv
// rtl/sd_stream_ctrl.sv - byte stream to serial detector with match counter and interrupt
module sd_stream_ctrl
   import sd_pkg::*;
#(
   parameter int CNT_W = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [7:0]       cfg_pattern,
   input  logic [3:0]       cfg_len,
   input  logic [CNT_W-1:0] cfg_thresh,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             det_pulse,
   output logic [CNT_W-1:0] match_cnt,
   output logic             thresh_irq,
   input  logic             irq_clr,
   output logic             busy,
   output logic [1:0]       state_out
);

   sd_state_t        r_state;
   sd_state_t        w_next_state;
   logic [7:0]       r_byte;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_pattern;
   logic [3:0]       r_len;
   logic [CNT_W-1:0] r_thresh;
   logic             r_det;
   logic [CNT_W-1:0] r_cnt;
   logic             r_irq;

   logic             w_ready;
   logic             w_xfer;
   logic             w_shift;
   logic             w_hit;
   logic             w_cnt_inc;
   logic [CNT_W-1:0] w_cnt_plus;
   logic             w_irq_set;

   assign w_ready    = (r_state == SD_IDLE) || ((r_state == SD_SHIFT) && (r_bit_idx == 3'd0));
   assign w_xfer     = in_valid && w_ready;
   assign w_shift    = (r_state == SD_SHIFT);
   assign w_cnt_plus = r_cnt + 1'b1;
   assign w_cnt_inc  = w_hit && (r_cnt != '1);
   assign w_irq_set  = w_cnt_inc && (r_thresh != '0) && (w_cnt_plus == r_thresh);

   assign in_ready   = w_ready;
   assign det_pulse  = r_det;
   assign match_cnt  = r_cnt;
   assign thresh_irq = r_irq;
   assign state_out  = r_state;

   // State register; only legal encodings are ever loaded
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= SD_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state: stay in SHIFT across the last bit when the next byte is handed over
   always_comb begin
      w_next_state = SD_IDLE;
      busy         = 1'b0;
      case (r_state)
         SD_IDLE: begin
            w_next_state = in_valid ? SD_SHIFT : SD_IDLE;
         end
         SD_SHIFT: begin
            busy = 1'b1;
            if (r_bit_idx != 3'd0) begin
               w_next_state = SD_SHIFT;
            end else begin
               w_next_state = in_valid ? SD_SHIFT : SD_IDLE;
            end
         end
         default: begin
            w_next_state = SD_IDLE;
         end
      endcase
   end

   // Byte and configuration are captured together so cfg edits only apply per byte
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_byte    <= '0;
         r_bit_idx <= 3'd7;
         r_pattern <= '0;
         r_len     <= '0;
         r_thresh  <= '0;
      end else if (w_xfer) begin
         r_byte    <= in_data;
         r_bit_idx <= 3'd7;
         r_pattern <= cfg_pattern;
         r_len     <= clamp_len(cfg_len);
         r_thresh  <= cfg_thresh;
      end else if (w_shift) begin
         r_bit_idx <= r_bit_idx - 3'd1;
      end
   end

   sd_shift_match u_match (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (clr),
      .i_shift_en (w_shift),
      .i_bit      (r_byte[r_bit_idx]),
      .i_len      (r_len),
      .i_pattern  (r_pattern),
      .o_hit      (w_hit)
   );

   // Match strobe, saturating count and sticky interrupt where a new set beats irq_clr
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_det <= 1'b0;
         r_cnt <= '0;
         r_irq <= 1'b0;
      end else begin
         r_det <= w_hit;
         if (clr) begin
            r_cnt <= '0;
            r_irq <= 1'b0;
         end else begin
            if (w_cnt_inc) begin
               r_cnt <= w_cnt_plus;
            end
            if (w_irq_set) begin
               r_irq <= 1'b1;
            end else if (irq_clr) begin
               r_irq <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_sd_stream_ctrl.sv
// tb/tb_sd_stream_ctrl.sv - directed vector bench for sd_stream_ctrl
module tb_sd_stream_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       clr;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic [7:0] cfg_thresh;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       det_pulse;
   logic [7:0] match_cnt;
   logic       thresh_irq;
   logic       irq_clr;
   logic       busy;
   logic [1:0] state_out;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      logic       clr;
      logic       vld;
      logic [7:0] data;
      logic       irqc;
      logic       rdy;
      logic       det;
      logic [7:0] cnt;
      logic       irq;
      logic       busy;
   } vec_t;

   vec_t vecs[$];

   sd_stream_ctrl #(.CNT_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .clr         (clr),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_thresh  (cfg_thresh),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .det_pulse   (det_pulse),
      .match_cnt   (match_cnt),
      .thresh_irq  (thresh_irq),
      .irq_clr     (irq_clr),
      .busy        (busy),
      .state_out   (state_out)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic clr_irq_last, output int pulses);
      pulses   = 0;
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (k == 8) irq_clr = clr_irq_last;
         step();
         irq_clr = 1'b0;
         if (det_pulse) pulses++;
      end
   endtask

   function automatic void add(input logic c, input logic v, input logic [7:0] d, input logic ic,
                               input logic r, input logic dt, input logic [7:0] n,
                               input logic iq, input logic b);
      vec_t e;
      e.clr = c; e.vld = v; e.data = d; e.irqc = ic;
      e.rdy = r; e.det = dt; e.cnt = n; e.irq = iq; e.busy = b;
      vecs.push_back(e);
   endfunction

   // Cycle-by-cycle expectations with pattern 4'b1011 (len 4), thresh 3
   function automatic void build_table();
      // single byte 0x0B: one match completing at E8
      add(1, 0, 8'h00, 0,  1, 0, 0, 0, 0);
      add(0, 1, 8'h0B, 0,  0, 0, 0, 0, 1);
      for (int i = 1; i <= 6; i++) add(0, 0, 8'h00, 0,  0, 0, 0, 0, 1);
      add(0, 0, 8'h00, 0,  1, 0, 0, 0, 1);
      add(0, 0, 8'h00, 0,  1, 1, 1, 0, 0);
      add(0, 0, 8'h00, 0,  1, 0, 1, 0, 0);
      // 0xB6: overlapping matches at E4 and E7
      add(1, 0, 8'h00, 0,  1, 0, 0, 0, 0);
      add(0, 1, 8'hB6, 0,  0, 0, 0, 0, 1);
      add(0, 0, 8'h00, 0,  0, 0, 0, 0, 1);
      add(0, 0, 8'h00, 0,  0, 0, 0, 0, 1);
      add(0, 0, 8'h00, 0,  0, 0, 0, 0, 1);
      add(0, 0, 8'h00, 0,  0, 1, 1, 0, 1);
      add(0, 0, 8'h00, 0,  0, 0, 1, 0, 1);
      add(0, 0, 8'h00, 0,  0, 0, 1, 0, 1);
      add(0, 0, 8'h00, 0,  1, 1, 2, 0, 1);
      add(0, 0, 8'h00, 0,  1, 0, 2, 0, 0);
      // 0x01 then 0x60 back-to-back: one match spanning the boundary at E11
      add(1, 0, 8'h00, 0,  1, 0, 0, 0, 0);
      add(0, 1, 8'h01, 0,  0, 0, 0, 0, 1);
      for (int i = 1; i <= 6; i++) add(0, 0, 8'h00, 0,  0, 0, 0, 0, 1);
      add(0, 0, 8'h00, 0,  1, 0, 0, 0, 1);
      add(0, 1, 8'h60, 0,  0, 0, 0, 0, 1);
      add(0, 0, 8'h00, 0,  0, 0, 0, 0, 1);
      add(0, 0, 8'h00, 0,  0, 0, 0, 0, 1);
      add(0, 0, 8'h00, 0,  0, 1, 1, 0, 1);
      add(0, 0, 8'h00, 0,  0, 0, 1, 0, 1);
      add(0, 0, 8'h00, 0,  0, 0, 1, 0, 1);
      add(0, 0, 8'h00, 0,  0, 0, 1, 0, 1);
      add(0, 0, 8'h00, 0,  1, 0, 1, 0, 1);
      add(0, 0, 8'h00, 0,  1, 0, 1, 0, 0);
   endfunction

   initial begin
      int p;
      rst         = 1'b0;
      clr         = 1'b0;
      irq_clr     = 1'b0;
      in_valid    = 1'b0;
      in_data     = 8'h00;
      cfg_pattern = 8'h0B;
      cfg_len     = 4'd4;
      cfg_thresh  = 8'd3;

      #12;
      chk("reset_ready", 0, in_ready,   1);
      chk("reset_det",   0, det_pulse,  0);
      chk("reset_cnt",   0, match_cnt,  0);
      chk("reset_irq",   0, thresh_irq, 0);
      chk("reset_busy",  0, busy,       0);
      chk("reset_state", 0, state_out,  0);
      rst = 1'b1;
      step();

      build_table();
      for (int i = 0; i < vecs.size(); i++) begin
         vec_t v;
         v        = vecs[i];
         clr      = v.clr;
         in_valid = v.vld;
         in_data  = v.data;
         irq_clr  = v.irqc;
         step();
         chk("tbl_ready", i, in_ready,   v.rdy);
         chk("tbl_det",   i, det_pulse,  v.det);
         chk("tbl_cnt",   i, match_cnt,  v.cnt);
         chk("tbl_irq",   i, thresh_irq, v.irq);
         chk("tbl_busy",  i, busy,       v.busy);
      end
      clr      = 1'b0;
      in_valid = 1'b0;
      irq_clr  = 1'b0;

      // cfg edits after acceptance do not affect the byte in flight
      do_clr();
      p = 0;
      in_valid = 1'b1;
      in_data  = 8'h0B;
      step();
      in_valid    = 1'b0;
      cfg_len     = 4'd0;
      cfg_pattern = 8'hFF;
      for (int k = 0; k < 8; k++) begin
         step();
         if (det_pulse) p++;
      end
      chk("shadow_pulses", 0, p, 1);
      cfg_len     = 4'd4;
      cfg_pattern = 8'h0B;

      // length above 8 compares all 8 history bits
      do_clr();
      cfg_len = 4'd15;
      send_byte(8'h0B, 1'b0, p);
      chk("clamp_pulses", 0, p, 1);
      chk("clamp_cnt",    0, match_cnt, 1);
      cfg_len = 4'd4;

      // threshold interrupt, irq_clr, and set winning over a simultaneous clear
      do_clr();
      send_byte(8'h0B, 1'b0, p);
      chk("thr_cnt", 1, match_cnt, 1);
      chk("thr_irq", 1, thresh_irq, 0);
      send_byte(8'h0B, 1'b0, p);
      chk("thr_irq", 2, thresh_irq, 0);
      send_byte(8'h0B, 1'b0, p);
      chk("thr_cnt", 3, match_cnt, 3);
      chk("thr_irq", 3, thresh_irq, 1);
      irq_clr = 1'b1;
      step();
      irq_clr = 1'b0;
      chk("irqclr_irq", 0, thresh_irq, 0);
      chk("irqclr_cnt", 0, match_cnt, 3);
      do_clr();
      send_byte(8'h0B, 1'b0, p);
      send_byte(8'h0B, 1'b0, p);
      send_byte(8'h0B, 1'b1, p);
      chk("setwins_irq", 0, thresh_irq, 1);
      chk("setwins_cnt", 0, match_cnt, 3);

      // asynchronous reset in the middle of a byte
      in_valid = 1'b1;
      in_data  = 8'h0B;
      step();
      in_valid = 1'b0;
      step();
      step();
      step();
      rst = 1'b0;
      #2;
      chk("midrst_ready", 0, in_ready,   1);
      chk("midrst_busy",  0, busy,       0);
      chk("midrst_state", 0, state_out,  0);
      chk("midrst_cnt",   0, match_cnt,  0);
      chk("midrst_irq",   0, thresh_irq, 0);
      chk("midrst_det",   0, det_pulse,  0);
      rst = 1'b1;
      #1;
      send_byte(8'h0B, 1'b0, p);
      chk("postrst_pulses", 0, p, 1);
      chk("postrst_cnt",    0, match_cnt, 1);

      // counter saturation with a single-bit pattern, then detection disabled
      cfg_len     = 4'd1;
      cfg_pattern = 8'h01;
      do_clr();
      for (int b = 0; b < 32; b++) begin
         send_byte(8'hFF, 1'b0, p);
         if (b == 30) chk("sat_cnt31", 0, match_cnt, 248);
      end
      chk("sat_cnt32", 0, match_cnt, 255);
      chk("sat_irq",   0, thresh_irq, 1);
      cfg_len     = 4'd0;
      cfg_pattern = 8'h00;
      send_byte(8'h00, 1'b0, p);
      chk("len0_pulses", 0, p, 0);
      chk("len0_cnt",    0, match_cnt, 255);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/sd_stream_ctrl.md
Name: sd_stream_ctrl

Overview:
- Controller that feeds a programmable serial sequence detector from a byte stream.
- Accepts bytes over a valid/ready handshake and shifts them MSB-first, one bit per clock, into an 8-bit history.
- Flags every overlapping match of a 1..8-bit pattern, counts matches, and raises a sticky interrupt when a programmed threshold is reached.
- Sits between a byte-wide producer and the software-visible status/interrupt logic.

Parameters:
- CNT_W, 8, width of match counter and threshold.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous soft clear of history, fill count, match_cnt, thresh_irq
- cfg_pattern  in  8  pattern, right-aligned; the low cfg_len bits are used, LSB is the most recent bit
- cfg_len  in  4  pattern length; 0 disables detection; values >8 are treated as 8
- cfg_thresh  in  CNT_W  interrupt threshold; 0 disables the interrupt
- in_valid  in  1  producer has a byte
- in_data  in  8  byte to serialise, bit 7 first
- in_ready  out  1  controller can accept a byte this cycle
- det_pulse  out  1  one-cycle match strobe
- match_cnt  out  CNT_W  saturating match count
- thresh_irq  out  1  sticky threshold interrupt
- irq_clr  in  1  clears thresh_irq
- busy  out  1  high in SHIFT
- state_out  out  2  current FSM state, for debug

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, history=0, fill=0, bit_idx=7, det_pulse=0, match_cnt=0, thresh_irq=0, busy=0. in_ready=1 immediately after reset, since it is derived from state.
- States are IDLE=2'b00 and SHIFT=2'b01. 2'b10 and 2'b11 are illegal and recover to IDLE on the next edge.
- in_ready = (state==IDLE) || (state==SHIFT && bit_idx==0). A transfer occurs on a rising edge with in_valid && in_ready.
- On transfer:
  - latch in_data into the shift byte;
  - latch cfg_pattern, cfg_len and cfg_thresh into shadow registers; cfg changes between transfers have no effect;
  - bit_idx <= 7;
  - state <= SHIFT.
- SHIFT, each edge:
  - history <= {history[6:0], byte[bit_idx]};
  - fill <= min(fill+1, 8);
  - bit_idx decrements.
- End of byte: at the bit_idx==0 edge, state <= SHIFT if a new transfer happens at that edge, else IDLE.
- Timing: byte accepted at edge E0 shifts bits 7..0 at edges E1..E8. Back-to-back bytes give 8 cycles/byte with no bubble. The next byte's bit 7 enters at E9.
- Match: at each shifting edge, compute hit = (len!=0) && (next_fill >= len) && (next_history[len-1:0] == pattern[len-1:0]). det_pulse <= hit.
  - det_pulse is therefore high in the cycle following the edge at which the completing bit entered.
- Overlapping matches are all reported.
- History is kept across byte boundaries and IDLE gaps; matches spanning bytes are detected.
- match_cnt increments on each hit and saturates at 2^CNT_W-1.
- thresh_irq is set on the edge where match_cnt becomes equal to the shadow thresh (thresh!=0). It stays set until irq_clr. If set and irq_clr occur on the same edge, set wins.
- clr:
  - clears history, fill, match_cnt and thresh_irq on that edge;
  - does not affect state or the byte in flight;
  - bits shifted on that same edge are discarded from the history.
- Reset asserted mid-byte: the byte is discarded and all values return to reset values asynchronously.

Decomposition:
- Package sd_pkg holds the state encodings (SD_IDLE, SD_SHIFT), HIST_W=8, and the cfg_len clamp constant.
- One sub-module, sd_shift_match, holds the history shift register, the fill counter and the masked compare. It exports hit.
- The top level holds the FSM, handshake, counter and interrupt.

Test Plan:
- Match within one byte: pattern=8'h0B, len=4, send 8'h0B once → in_ready low E1..E7; one det_pulse in the cycle after E8; match_cnt=1.
- Overlapping matches: send 8'hB6 (1,0,1,1,0,1,1,0) after clr → det_pulse after E4 and after E7; match_cnt=2.
- Cross-byte match: 8'h01 then 8'h60 back-to-back → second byte accepted at E8 with no bubble; single det_pulse after E11; match_cnt=1.
- Threshold interrupt: cfg_thresh=3, send 8'h0B three times → thresh_irq rises with match_cnt=3.
  - irq_clr pulse clears it.
  - irq_clr on the same edge as a new threshold hit leaves it set.
- Reset mid-byte: drop rst after E3 → all outputs at reset values; in_ready=1. The next 8'h0B yields exactly one match.
- Counter saturation: len=1, pattern=1, send 32 bytes of 8'hFF → match_cnt stays 255; 8'h00 with len=0 → no det_pulse.
